fifo_csr_irq: RTL and testbench
===============================

FIFO_CSR_IRQ -- requirements
Module: fifo_csr_irq

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning data and CSR word width in bits; legal only if WIDTH >= AW+1 and WIDTH >= 4.
REQ-002 SHALL have parameter DEPTH, default 16, meaning FIFO entries; legal only for a power of two >= 4; AW = log2(DEPTH) is derived internally.
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port avalon_address  input  3  CSR word address.
REQ-006 SHALL have port avalon_write  input  1  write strobe, one transfer per cycle.
REQ-007 SHALL have port avalon_read  input  1  read strobe, one transfer per cycle.
REQ-008 SHALL have port avalon_writedata  input  WIDTH  write data.
REQ-009 SHALL have port avalon_readdata  output  WIDTH  registered read data.
REQ-010 SHALL have port avalon_readdatavalid  output  1  high for one cycle when avalon_readdata is valid.
REQ-011 SHALL have port full  output  1  occupancy == DEPTH.
REQ-012 SHALL have port empty  output  1  occupancy == 0.
REQ-013 SHALL have port irq  output  1  level-sensitive interrupt.

Function
REQ-014 SHALL hold the register map: 0 STATUS, 1 POP, 2 PUSH, 3 LEVEL, 4 THRESH, 5 CTRL; 6-7 unmapped.
REQ-015 SHALL present STATUS as bit0 empty, bit1 full, bit2 overflow (sticky), bit3 underflow (sticky), other bits 0; writing 1 to bit2/bit3 clears that flag, writing 0 has no effect.
REQ-016 SHALL, on a write to PUSH with full low, store writedata at wr_ptr and increment wr_ptr modulo 2*DEPTH (AW+1-bit pointer, index = low AW bits).
REQ-017 SHALL, on a write to PUSH with full high, discard the data, leave the pointers unchanged, and set overflow.
REQ-018 SHALL, on a read of POP with empty low, return mem[rd_ptr] and increment rd_ptr modulo 2*DEPTH.
REQ-019 SHALL, on a read of POP with empty high, return 0, leave rd_ptr unchanged, and set underflow.
REQ-020 SHALL define occupancy = wr_ptr - rd_ptr ((AW+1)-bit); full and empty derive from it, and LEVEL reads it zero-extended.
REQ-021 SHALL make THRESH read/write, with the low AW+1 bits significant and the upper bits reading 0.
REQ-022 SHALL give CTRL bit0 irq_en (R/W) and bit1 flush (write-1 self-clearing, always reads 0).
REQ-023 SHALL, on flush, zero both pointers in that cycle; flags, THRESH and irq_en are unchanged, and storage contents are don't-care.
REQ-024 SHALL register every read: avalon_readdata and avalon_readdatavalid=1 on the edge after the read cycle; otherwise avalon_readdatavalid=0 and avalon_readdata holds its value.
REQ-025 SHALL, when avalon_write and avalon_read are both high in one cycle, perform only the write; no read side effect occurs and no readdatavalid is issued.
REQ-026 SHALL return 0 for reads of unmapped addresses, with readdatavalid still issued, and SHALL ignore writes to unmapped addresses.
REQ-027 SHALL drive irq = irq_en AND (occupancy >= THRESH OR overflow OR underflow), combinationally from registered state.
REQ-028 SHALL make full, empty and LEVEL reflect a push or pop from the edge that performs it.
REQ-029 SHALL give a STATUS read issued in the same cycle as an event the pre-edge values.
REQ-030 SHALL not reset the storage array.

Reset
REQ-031 SHALL, while reset is high, immediately force: pointers 0, overflow 0, underflow 0, THRESH = DEPTH/2, irq_en 0, avalon_readdata 0, avalon_readdatavalid 0.
REQ-032 SHALL, as a result of REQ-031, drive empty 1, full 0 and irq 0 during reset.
REQ-033 SHALL discard, on reset asserted mid-transfer, any pending readdatavalid, with no pointer update from that cycle.

Verification
REQ-034 SHALL cover: reset, then PUSH 0xA5, then POP -> readdatavalid one cycle later with readdata 0xA5; empty 1 afterwards.
REQ-035 SHALL cover, with DEPTH=16: 17 PUSHes of values 0..16 -> full 1 after the 16th, overflow set on the 17th; 16 POPs return 0..15 in order with pointer wrap correct.
REQ-036 SHALL cover: POP on empty -> readdata 0, readdatavalid 1, STATUS = 0x9; then write 0x8 to STATUS -> STATUS = 0x1.
REQ-037 SHALL cover: THRESH=4, CTRL=0x1, then 3 PUSHes -> irq 0; 4th PUSH -> irq 1; 1 POP -> irq 0.
REQ-038 SHALL cover: 5 PUSHes, then CTRL=0x2 -> LEVEL 0, empty 1, CTRL reads 0x1 if irq_en was set.
REQ-039 SHALL cover: read and write asserted together at PUSH/POP -> push only, no readdatavalid; reset asserted mid-sequence -> outputs at REQ-031 values asynchronously.

Source files
------------

// File: rtl/fifo_csr_irq.sv
// Memory-mapped FIFO with status/control registers and a level-sensitive interrupt.
// Pushes and pops happen through CSR writes and reads. Every read returns its data through a registered response.
module fifo_csr_irq #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       avalon_address,
  input  logic             avalon_write,
  input  logic             avalon_read,
  input  logic [WIDTH-1:0] avalon_writedata,
  output logic [WIDTH-1:0] avalon_readdata,
  output logic             avalon_readdatavalid,
  output logic             full,
  output logic             empty,
  output logic             irq
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [2:0] ADDR_STATUS = 3'd0;
  localparam logic [2:0] ADDR_POP    = 3'd1;
  localparam logic [2:0] ADDR_PUSH   = 3'd2;
  localparam logic [2:0] ADDR_LEVEL  = 3'd3;
  localparam logic [2:0] ADDR_THRESH = 3'd4;
  localparam logic [2:0] ADDR_CTRL   = 3'd5;

  localparam logic [AW:0] THRESH_RST = (AW+1)'(DEPTH / 2);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [AW:0]      occupancy;
  logic [AW:0]      thresh;
  logic             overflow;
  logic             underflow;
  logic             irq_en;

  logic             read_en;
  logic             push_ok;
  logic             push_drop;
  logic             pop_ok;
  logic             pop_empty;
  logic             wr_status;
  logic             wr_thresh;
  logic             wr_ctrl;
  logic [WIDTH-1:0] rd_word;

  assign occupancy = wr_ptr - rd_ptr;
  assign full      = (occupancy == (AW+1)'(DEPTH));
  assign empty     = (occupancy == '0);
  assign irq       = irq_en & ((occupancy >= thresh) | overflow | underflow);

  // A write in the same cycle as a read wins; the read is dropped entirely.
  assign read_en   = avalon_read & ~avalon_write;
  assign push_ok   = avalon_write & (avalon_address == ADDR_PUSH) & ~full;
  assign push_drop = avalon_write & (avalon_address == ADDR_PUSH) & full;
  assign pop_ok    = read_en & (avalon_address == ADDR_POP) & ~empty;
  assign pop_empty = read_en & (avalon_address == ADDR_POP) & empty;
  assign wr_status = avalon_write & (avalon_address == ADDR_STATUS);
  assign wr_thresh = avalon_write & (avalon_address == ADDR_THRESH);
  assign wr_ctrl   = avalon_write & (avalon_address == ADDR_CTRL);

  always_comb begin
    rd_word = '0;
    case (avalon_address)
      ADDR_STATUS: rd_word[3:0] = {underflow, overflow, full, empty};
      ADDR_POP:    if (!empty) rd_word = mem[rd_ptr[AW-1:0]];
      ADDR_LEVEL:  rd_word[AW:0] = occupancy;
      ADDR_THRESH: rd_word[AW:0] = thresh;
      ADDR_CTRL:   rd_word[0] = irq_en;
      default:     rd_word = '0;
    endcase
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr[AW-1:0]] <= avalon_writedata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr               <= '0;
      rd_ptr               <= '0;
      overflow             <= 1'b0;
      underflow            <= 1'b0;
      thresh               <= THRESH_RST;
      irq_en               <= 1'b0;
      avalon_readdata      <= '0;
      avalon_readdatavalid <= 1'b0;
    end else begin
      avalon_readdatavalid <= read_en;
      if (read_en) begin
        avalon_readdata <= rd_word;
      end
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (push_drop) begin
        overflow <= 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (pop_empty) begin
        underflow <= 1'b1;
      end
      if (wr_status) begin
        if (avalon_writedata[2]) overflow  <= 1'b0;
        if (avalon_writedata[3]) underflow <= 1'b0;
      end
      if (wr_thresh) begin
        thresh <= avalon_writedata[AW:0];
      end
      // A flush write leaves irq_en alone so software can flush without re-arming.
      if (wr_ctrl) begin
        if (avalon_writedata[1]) begin
          wr_ptr <= '0;
          rd_ptr <= '0;
        end else begin
          irq_en <= avalon_writedata[0];
        end
      end
    end
  end

endmodule

// File: tb/tb_fifo_csr_irq.sv
// Bench for fifo_csr_irq: directed vector table, corner sequences, and randomized traffic
// checked against a queue-based reference model.
module tb_fifo_csr_irq;

  localparam int WIDTH = 8;
  localparam int DEPTH = 16;

  localparam logic [2:0] A_STATUS = 3'd0;
  localparam logic [2:0] A_POP    = 3'd1;
  localparam logic [2:0] A_PUSH   = 3'd2;
  localparam logic [2:0] A_LEVEL  = 3'd3;
  localparam logic [2:0] A_THRESH = 3'd4;
  localparam logic [2:0] A_CTRL   = 3'd5;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [2:0]       avalon_address = '0;
  logic             avalon_write = 1'b0;
  logic             avalon_read = 1'b0;
  logic [WIDTH-1:0] avalon_writedata = '0;
  logic [WIDTH-1:0] avalon_readdata;
  logic             avalon_readdatavalid;
  logic             full;
  logic             empty;
  logic             irq;

  int errors = 0;
  int checks = 0;

  fifo_csr_irq #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk                  (clk),
    .reset                (reset),
    .avalon_address       (avalon_address),
    .avalon_write         (avalon_write),
    .avalon_read          (avalon_read),
    .avalon_writedata     (avalon_writedata),
    .avalon_readdata      (avalon_readdata),
    .avalon_readdatavalid (avalon_readdatavalid),
    .full                 (full),
    .empty                (empty),
    .irq                  (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         wr;
    bit         rd;
    logic [2:0] addr;
    logic [7:0] wdata;
    bit         chk_rdata;
    logic [7:0] exp_rdata;
    bit         exp_valid;
    bit         exp_full;
    bit         exp_empty;
    bit         exp_irq;
  } vec_t;

  vec_t vecs[$];

  // Reference model state
  logic [7:0] m_q[$];
  bit         m_ovf;
  bit         m_udf;
  int         m_thresh;
  bit         m_irq_en;

  function automatic vec_t mk(bit wr, bit rd, logic [2:0] addr, logic [7:0] wdata,
                              bit chk_rdata, logic [7:0] exp_rdata, bit exp_valid,
                              bit exp_full, bit exp_empty, bit exp_irq);
    vec_t v;
    v.wr = wr; v.rd = rd; v.addr = addr; v.wdata = wdata;
    v.chk_rdata = chk_rdata; v.exp_rdata = exp_rdata; v.exp_valid = exp_valid;
    v.exp_full = exp_full; v.exp_empty = exp_empty; v.exp_irq = exp_irq;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One bus cycle; starts and ends 1 time unit after a rising edge.
  task automatic cycle(input bit wr, input bit rd, input logic [2:0] addr, input logic [7:0] d);
    avalon_write     = wr;
    avalon_read      = rd;
    avalon_address   = addr;
    avalon_writedata = d;
    @(posedge clk);
    #1;
    avalon_write = 1'b0;
    avalon_read  = 1'b0;
    $display("txn wr=%0d rd=%0d addr=%0d wdata=0x%02h -> rdata=0x%02h valid=%0d full=%0d empty=%0d irq=%0d",
             wr, rd, addr, d, avalon_readdata, avalon_readdatavalid, full, empty, irq);
  endtask

  task automatic rd_check(input string name, input logic [2:0] addr, input logic [7:0] exp);
    cycle(1'b0, 1'b1, addr, 8'h00);
    check({name, ".valid"}, {31'b0, avalon_readdatavalid}, 32'd1);
    check({name, ".data"}, {24'b0, avalon_readdata}, {24'b0, exp});
  endtask

  task automatic model_reset();
    m_q.delete();
    m_ovf = 0;
    m_udf = 0;
    m_thresh = DEPTH / 2;
    m_irq_en = 0;
  endtask

  // Applies one bus transfer to the model; returns the read response it should produce.
  task automatic model_apply(input bit wr, input bit rd, input logic [2:0] addr,
                             input logic [7:0] d, output logic [7:0] exp_rd, output bit exp_v);
    exp_rd = 8'h00;
    exp_v  = 1'b0;
    if (wr) begin
      case (addr)
        A_PUSH:   if (m_q.size() < DEPTH) m_q.push_back(d); else m_ovf = 1;
        A_STATUS: begin if (d[2]) m_ovf = 0; if (d[3]) m_udf = 0; end
        A_THRESH: m_thresh = int'(d[4:0]);
        A_CTRL:   if (d[1]) m_q.delete(); else m_irq_en = d[0];
        default:  ;
      endcase
    end else if (rd) begin
      exp_v = 1'b1;
      case (addr)
        A_STATUS: exp_rd = {4'b0, m_udf, m_ovf, m_q.size() == DEPTH, m_q.size() == 0};
        A_POP:    if (m_q.size() > 0) exp_rd = m_q.pop_front(); else m_udf = 1;
        A_LEVEL:  exp_rd = 8'(m_q.size());
        A_THRESH: exp_rd = 8'(m_thresh);
        A_CTRL:   exp_rd = {7'b0, m_irq_en};
        default:  exp_rd = 8'h00;
      endcase
    end
  endtask

  initial begin
    logic [7:0] exp_rd;
    bit         exp_v;
    bit         wr;
    bit         rd;
    logic [2:0] addr;
    logic [7:0] d;

    // Reset state, asserted asynchronously away from any clock edge.
    #2 reset = 1'b1;
    #1;
    check("rst.valid", {31'b0, avalon_readdatavalid}, 32'd0);
    check("rst.rdata", {24'b0, avalon_readdata}, 32'd0);
    check("rst.empty", {31'b0, empty}, 32'd1);
    check("rst.full",  {31'b0, full},  32'd0);
    check("rst.irq",   {31'b0, irq},   32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Directed vector table (wr, rd, addr, wdata, chk_rdata, rdata, valid, full, empty, irq)
    vecs.push_back(mk(1, 0, A_PUSH,   8'hA5, 0, 8'h00, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, A_POP,    8'h00, 1, 8'hA5, 1, 0, 1, 0));
    vecs.push_back(mk(0, 1, A_POP,    8'h00, 1, 8'h00, 1, 0, 1, 0));
    vecs.push_back(mk(0, 1, A_STATUS, 8'h00, 1, 8'h09, 1, 0, 1, 0));
    vecs.push_back(mk(1, 0, A_STATUS, 8'h08, 0, 8'h00, 0, 0, 1, 0));
    vecs.push_back(mk(0, 1, A_STATUS, 8'h00, 1, 8'h01, 1, 0, 1, 0));
    vecs.push_back(mk(1, 0, A_THRESH, 8'h04, 0, 8'h00, 0, 0, 1, 0));
    vecs.push_back(mk(1, 0, A_CTRL,   8'h01, 0, 8'h00, 0, 0, 1, 0));
    vecs.push_back(mk(1, 0, A_PUSH,   8'h11, 0, 8'h00, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, A_PUSH,   8'h22, 0, 8'h00, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, A_PUSH,   8'h44, 0, 8'h00, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, A_PUSH,   8'h88, 0, 8'h00, 0, 0, 0, 1));
    vecs.push_back(mk(0, 1, A_POP,    8'h00, 1, 8'h11, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, A_LEVEL,  8'h00, 1, 8'h03, 1, 0, 0, 0));
    vecs.push_back(mk(1, 1, A_PUSH,   8'h99, 0, 8'h00, 0, 0, 0, 1));
    vecs.push_back(mk(1, 0, A_CTRL,   8'h02, 0, 8'h00, 0, 0, 1, 0));
    vecs.push_back(mk(0, 1, A_CTRL,   8'h00, 1, 8'h01, 1, 0, 1, 0));
    vecs.push_back(mk(0, 1, A_LEVEL,  8'h00, 1, 8'h00, 1, 0, 1, 0));
    vecs.push_back(mk(0, 1, A_THRESH, 8'h00, 1, 8'h04, 1, 0, 1, 0));
    vecs.push_back(mk(0, 1, 3'd6,     8'h00, 1, 8'h00, 1, 0, 1, 0));
    vecs.push_back(mk(1, 0, 3'd7,     8'hFF, 0, 8'h00, 0, 0, 1, 0));
    vecs.push_back(mk(0, 1, A_THRESH, 8'h00, 1, 8'h04, 1, 0, 1, 0));
    vecs.push_back(mk(1, 1, A_PUSH,   8'h33, 0, 8'h00, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, A_POP,    8'h00, 1, 8'h33, 1, 0, 1, 0));
    vecs.push_back(mk(1, 0, A_PUSH,   8'h55, 0, 8'h00, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, A_POP,    8'h00, 0, 8'h00, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, A_LEVEL,  8'h00, 1, 8'h01, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, A_POP,    8'h00, 1, 8'h55, 1, 0, 1, 0));

    foreach (vecs[i]) begin
      cycle(vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].wdata);
      check($sformatf("vec%0d.valid", i), {31'b0, avalon_readdatavalid}, {31'b0, vecs[i].exp_valid});
      if (vecs[i].chk_rdata)
        check($sformatf("vec%0d.rdata", i), {24'b0, avalon_readdata}, {24'b0, vecs[i].exp_rdata});
      check($sformatf("vec%0d.full", i),  {31'b0, full},  {31'b0, vecs[i].exp_full});
      check($sformatf("vec%0d.empty", i), {31'b0, empty}, {31'b0, vecs[i].exp_empty});
      check($sformatf("vec%0d.irq", i),   {31'b0, irq},   {31'b0, vecs[i].exp_irq});
    end

    // Fill to capacity, overflow on the 17th push, then drain in order across the pointer wrap.
    for (int i = 0; i < DEPTH + 1; i++) begin
      cycle(1'b1, 1'b0, A_PUSH, 8'(i));
      check($sformatf("fill%0d.full", i), {31'b0, full}, {31'b0, (i >= DEPTH - 1)});
      check($sformatf("fill%0d.empty", i), {31'b0, empty}, 32'd0);
    end
    rd_check("fill.status", A_STATUS, 8'h06);
    rd_check("fill.level", A_LEVEL, 8'd16);
    for (int i = 0; i < DEPTH; i++) begin
      rd_check($sformatf("drain%0d", i), A_POP, 8'(i));
      check($sformatf("drain%0d.full", i), {31'b0, full}, 32'd0);
    end
    check("drain.empty", {31'b0, empty}, 32'd1);
    cycle(1'b1, 1'b0, A_STATUS, 8'h04);
    rd_check("ovf_clear.status", A_STATUS, 8'h01);

    // Asynchronous reset in the middle of a POP transfer.
    cycle(1'b1, 1'b0, A_THRESH, 8'h00);
    check("pre_rst.irq", {31'b0, irq}, 32'd1);
    cycle(1'b1, 1'b0, A_PUSH, 8'h77);
    cycle(1'b1, 1'b0, A_PUSH, 8'h78);
    rd_check("pre_rst.pop", A_POP, 8'h77);
    avalon_read    = 1'b1;
    avalon_address = A_POP;
    #2 reset = 1'b1;
    #1;
    check("mid_rst.valid", {31'b0, avalon_readdatavalid}, 32'd0);
    check("mid_rst.rdata", {24'b0, avalon_readdata}, 32'd0);
    check("mid_rst.empty", {31'b0, empty}, 32'd1);
    check("mid_rst.full",  {31'b0, full},  32'd0);
    check("mid_rst.irq",   {31'b0, irq},   32'd0);
    @(posedge clk);
    #1;
    check("hold_rst.valid", {31'b0, avalon_readdatavalid}, 32'd0);
    reset = 1'b0;
    avalon_read = 1'b0;
    rd_check("post_rst.level",  A_LEVEL,  8'h00);
    rd_check("post_rst.thresh", A_THRESH, 8'h08);
    rd_check("post_rst.ctrl",   A_CTRL,   8'h00);
    rd_check("post_rst.status", A_STATUS, 8'h01);

    // Randomized traffic against the reference model.
    model_reset();
    for (int n = 0; n < 500; n++) begin
      int r;
      r = int'($urandom_range(0, 19));
      wr = 1'b0; rd = 1'b0; d = 8'($urandom);
      if (r <= 6)       begin wr = 1; addr = A_PUSH; end
      else if (r <= 11) begin rd = 1; addr = A_POP; end
      else if (r == 12) begin rd = 1; addr = A_STATUS; end
      else if (r == 13) begin rd = 1; addr = A_LEVEL; end
      else if (r == 14) begin wr = 1; addr = A_STATUS; end
      else if (r == 15) begin wr = 1; addr = A_THRESH; d = 8'($urandom_range(0, 18)); end
      else if (r == 16) begin
        wr = 1; addr = A_CTRL;
        d = ($urandom_range(0, 3) == 0) ? 8'h02 : 8'($urandom_range(0, 1));
      end
      else if (r == 17) begin wr = 1; rd = 1; addr = 3'($urandom_range(0, 7)); end
      else if (r == 18) begin rd = 1; addr = ($urandom_range(0, 1) == 0) ? A_THRESH : A_CTRL; end
      else              begin rd = 1; addr = 3'($urandom_range(6, 7)); end
      model_apply(wr, rd, addr, d, exp_rd, exp_v);
      cycle(wr, rd, addr, d);
      check($sformatf("rnd%0d.valid", n), {31'b0, avalon_readdatavalid}, {31'b0, exp_v});
      if (exp_v)
        check($sformatf("rnd%0d.rdata", n), {24'b0, avalon_readdata}, {24'b0, exp_rd});
      check($sformatf("rnd%0d.full", n),  {31'b0, full},  {31'b0, m_q.size() == DEPTH});
      check($sformatf("rnd%0d.empty", n), {31'b0, empty}, {31'b0, m_q.size() == 0});
      check($sformatf("rnd%0d.irq", n),   {31'b0, irq},
            {31'b0, m_irq_en && ((m_q.size() >= m_thresh) || m_ovf || m_udf)});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
